// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
package cpu_pkg;

  localparam int unsigned XLEN               = 32;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS_DEFAULT = 128;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// PC register with next-PC selection, fetch range check and sticky fault flag.
module instruction_fetch_unit_pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  input  logic            advance,
  input  logic            fetch,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4_c,
  output logic            in_range_c,
  output logic            fault
);

  logic [XLEN-1:0] pc_d;
  logic            fault_d;

  assign pc4_c      = pc + 32'd4;
  assign in_range_c = {2'b00, pc[XLEN-1:2]} < 32'(IMEM_WORDS);

  // Redirect beats advance; the target is forced word aligned.
  always_comb begin
    pc_d = pc;
    if (redirect) begin
      pc_d = {target[XLEN-1:2], 2'b00};
    end else if (advance) begin
      pc_d = pc4_c;
    end
  end

  assign fault_d = fault
                 | (redirect & (|target[1:0]))
                 | (~redirect & fetch & ~in_range_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      pc    <= pc_d;
      fault <= fault_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, ROM addressing, IF/ID pipeline register and BOOT/RUN/HALTED control.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC_DEFAULT,
  parameter int unsigned IMEM_WORDS = cpu_pkg::IMEM_WORDS_DEFAULT,
  parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic        halt_i,
  input  logic        resume_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rd_i,
  output logic [31:0] instr_id_o,
  output logic [31:0] pc_id_o,
  output logic [31:0] pc4_id_o,
  output logic        valid_id_o,
  output logic        fault_o,
  output logic        halted_o
);

  import cpu_pkg::*;

  fetch_state_t    state_q, state_d;
  if_id_t          if_id_q, if_id_d, capture_c, bubble_c;
  logic [XLEN-1:0] pc, pc4_c;
  logic            in_range_c, advance, fetch, fault, halted_q;

  instruction_fetch_unit_pc_reg #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect_i),
    .target     (target_i),
    .advance    (advance),
    .fetch      (fetch),
    .pc         (pc),
    .pc4_c      (pc4_c),
    .in_range_c (in_range_c),
    .fault      (fault)
  );

  assign bubble_c  = if_id_t'({NOP_INSTR, 32'd0, 32'd0, 1'b0});
  assign capture_c = in_range_c ? if_id_t'({imem_rd_i, pc, pc4_c, 1'b1}) : bubble_c;

  // Next state / IF/ID selection; redirect overrides everything else.
  always_comb begin
    state_d = state_q;
    if_id_d = if_id_q;
    advance = 1'b0;
    fetch   = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        if_id_d = bubble_c;
      end
      RUN: begin
        if (!stall_i) begin
          fetch   = 1'b1;
          if_id_d = capture_c;
          if (halt_i) begin
            state_d = HALTED;
          end else begin
            advance = 1'b1;
          end
        end
      end
      HALTED: begin
        if_id_d = bubble_c;
        if (resume_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        if_id_d = bubble_c;
      end
    endcase
    if (redirect_i) begin
      if_id_d = bubble_c;
      fetch   = 1'b0;
      advance = 1'b0;
      state_d = (state_q == HALTED) ? HALTED : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      if_id_q  <= if_id_t'({NOP_INSTR, 32'd0, 32'd0, 1'b0});
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      if_id_q  <= if_id_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign imem_addr_o = pc;
  assign instr_id_o  = if_id_q.instr;
  assign pc_id_o     = if_id_q.pc;
  assign pc4_id_o    = if_id_q.pc4;
  assign valid_id_o  = if_id_q.valid;
  assign fault_o     = fault;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized run vs a reference model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall, redirect, halt, resume;
  logic [31:0] target;
  logic [31:0] imem_addr, imem_rd;
  logic [31:0] instr_id, pc_id, pc4_id;
  logic        valid_id, fault, halted;

  logic [31:0] rom [256];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pcid, m_pc4;
  logic        m_boot, m_halted, m_valid, m_fault;

  instruction_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall),
    .redirect_i  (redirect),
    .target_i    (target),
    .halt_i      (halt),
    .resume_i    (resume),
    .imem_addr_o (imem_addr),
    .imem_rd_i   (imem_rd),
    .instr_id_o  (instr_id),
    .pc_id_o     (pc_id),
    .pc4_id_o    (pc4_id),
    .valid_id_o  (valid_id),
    .fault_o     (fault),
    .halted_o    (halted)
  );

  assign imem_rd = rom[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcid = 32'h0; m_pc4 = 32'h0;
    m_boot = 1'b1; m_halted = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; target = 32'h0; halt = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model by the fetch rules, sample #1 after the edge.
  task automatic step(input logic s, input logic r, input logic [31:0] t, input logic h, input logic res);
    logic [31:0] cur;
    stall = s; redirect = r; target = t; halt = h; resume = res;
    cur = m_pc;
    if (r) begin
      m_pc = t & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_valid = 1'b0;
      if (t[1:0] != 2'b00) m_fault = 1'b1;
      m_boot = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_instr = 32'h0; m_valid = 1'b0;
    end else if (m_halted) begin
      m_instr = 32'h0; m_valid = 1'b0;
      if (res) m_halted = 1'b0;
    end else if (!s) begin
      if ((cur / 4) >= 128) begin
        m_instr = 32'h0; m_valid = 1'b0; m_fault = 1'b1;
      end else begin
        m_instr = rom[cur[9:2]]; m_pcid = cur; m_pc4 = cur + 32'd4; m_valid = 1'b1;
      end
      if (h) m_halted = 1'b1;
      else   m_pc = cur + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({imem_addr, instr_id, pc_id, pc4_id} !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_words got addr=%h instr=%h pc=%h pc4=%h exp all 0", imem_addr, instr_id, pc_id, pc4_id);
    end
    tests_run++;
    if ({valid_id, fault, halted} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags got v/f/h=%b%b%b exp 000", valid_id, fault, halted);
    end
  endtask

  task automatic test_boot_run();
    apply_reset();
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({imem_addr, instr_id, valid_id} !== {32'h0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL boot got addr=%h instr=%h v=%b exp 0/0/0", imem_addr, instr_id, valid_id);
    end
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({imem_addr, instr_id, pc_id, pc4_id, valid_id} !== {32'h4, 32'h11, 32'h0, 32'h4, 1'b1}) begin
      tests_failed++;
      $display("FAIL run_first got addr=%h instr=%h pc=%h pc4=%h v=%b exp 4/11/0/4/1",
               imem_addr, instr_id, pc_id, pc4_id, valid_id);
    end
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({imem_addr, instr_id, pc_id, valid_id} !== {32'h8, 32'h22, 32'h4, 1'b1}) begin
      tests_failed++;
      $display("FAIL run_second got addr=%h instr=%h pc=%h v=%b exp 8/22/4/1", imem_addr, instr_id, pc_id, valid_id);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      tests_run++;
      if ({imem_addr, instr_id, valid_id} !== {32'h8, 32'h22, 1'b1}) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d] got addr=%h instr=%h v=%b exp 8/22/1", i, imem_addr, instr_id, valid_id);
      end
    end
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({imem_addr, instr_id, pc_id, valid_id} !== {32'hC, 32'h33, 32'h8, 1'b1}) begin
      tests_failed++;
      $display("FAIL stall_release got addr=%h instr=%h pc=%h v=%b exp C/33/8/1", imem_addr, instr_id, pc_id, valid_id);
    end
  endtask

  task automatic test_redirect_over_stall();
    step(1, 1, 32'h40, 0, 0);
    tests_run++;
    if ({imem_addr, instr_id, valid_id} !== {32'h40, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL redirect_flush got addr=%h instr=%h v=%b exp 40/0/0", imem_addr, instr_id, valid_id);
    end
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({imem_addr, instr_id, pc_id, valid_id} !== {32'h44, rom[16], 32'h40, 1'b1}) begin
      tests_failed++;
      $display("FAIL redirect_fetch got addr=%h instr=%h pc=%h v=%b exp 44/%h/40/1",
               imem_addr, instr_id, pc_id, valid_id, rom[16]);
    end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h1F8, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({instr_id, pc_id, valid_id, fault} !== {rom[127], 32'h1FC, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL range_last got instr=%h pc=%h v=%b f=%b exp %h/1FC/1/0", instr_id, pc_id, valid_id, fault, rom[127]);
    end
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({imem_addr, instr_id, valid_id, fault} !== {32'h204, 32'h0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL range_fault got addr=%h instr=%h v=%b f=%b exp 204/0/0/1", imem_addr, instr_id, valid_id, fault);
    end
    step(0, 1, 32'h0, 0, 0);
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({instr_id, valid_id, fault} !== {32'h11, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL range_sticky got instr=%h v=%b f=%b exp 11/1/1", instr_id, valid_id, fault);
    end
  endtask

  task automatic test_misaligned();
    apply_reset();
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h13, 0, 0);
    tests_run++;
    if ({imem_addr, valid_id, fault} !== {32'h10, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL misaligned got addr=%h v=%b f=%b exp 10/0/1", imem_addr, valid_id, fault);
    end
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({instr_id, pc_id, valid_id} !== {rom[4], 32'h10, 1'b1}) begin
      tests_failed++;
      $display("FAIL misaligned_fetch got instr=%h pc=%h v=%b exp %h/10/1", instr_id, pc_id, valid_id, rom[4]);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    tests_run++;
    if ({halted, imem_addr, instr_id, pc_id, valid_id} !== {1'b1, 32'h8, 32'h33, 32'h8, 1'b1}) begin
      tests_failed++;
      $display("FAIL halt_enter got h=%b addr=%h instr=%h pc=%h v=%b exp 1/8/33/8/1",
               halted, imem_addr, instr_id, pc_id, valid_id);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0);
      tests_run++;
      if ({halted, imem_addr, valid_id} !== {1'b1, 32'h8, 1'b0}) begin
        tests_failed++;
        $display("FAIL halt_drain[%0d] got h=%b addr=%h v=%b exp 1/8/0", i, halted, imem_addr, valid_id);
      end
    end
    step(0, 0, 0, 0, 1);
    tests_run++;
    if ({halted, imem_addr} !== {1'b0, 32'h8}) begin
      tests_failed++;
      $display("FAIL resume got h=%b addr=%h exp 0/8", halted, imem_addr);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({imem_addr, instr_id, pc_id, valid_id} !== {32'h10, 32'h44, 32'hC, 1'b1}) begin
      tests_failed++;
      $display("FAIL resume_fetch got addr=%h instr=%h pc=%h v=%b exp 10/44/C/1", imem_addr, instr_id, pc_id, valid_id);
    end
  endtask

  task automatic test_halt_redirect();
    apply_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 32'h20, 0, 0);
    tests_run++;
    if ({halted, imem_addr, valid_id} !== {1'b1, 32'h20, 1'b0}) begin
      tests_failed++;
      $display("FAIL halt_redirect got h=%b addr=%h v=%b exp 1/20/0", halted, imem_addr, valid_id);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    tests_run++;
    if ({instr_id, pc_id, valid_id} !== {rom[8], 32'h20, 1'b1}) begin
      tests_failed++;
      $display("FAIL halt_redirect_fetch got instr=%h pc=%h v=%b exp %h/20/1", instr_id, pc_id, valid_id, rom[8]);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h13, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({imem_addr, instr_id, pc_id, pc4_id, valid_id, fault, halted} !== 131'h0) begin
      tests_failed++;
      $display("FAIL async_reset got addr=%h instr=%h pc=%h pc4=%h v/f/h=%b%b%b exp all 0",
               imem_addr, instr_id, pc_id, pc4_id, valid_id, fault, halted);
    end
    halt = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic        s, r, h, res;
    logic [31:0] t;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      s   = ($urandom_range(0, 99) < 20);
      r   = ($urandom_range(0, 99) < 8);
      h   = ($urandom_range(0, 99) < 5);
      res = ($urandom_range(0, 99) < 25);
      t   = 32'($urandom_range(0, 150)) << 2;
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
      step(s, r, t, h, res);
      tests_run++;
      if (imem_addr !== m_pc) begin
        tests_failed++;
        $display("FAIL rnd_addr cyc=%0d got %h exp %h", c, imem_addr, m_pc);
      end
      tests_run++;
      if ({instr_id, valid_id} !== {m_instr, m_valid}) begin
        tests_failed++;
        $display("FAIL rnd_ifid cyc=%0d got instr=%h v=%b exp %h/%b", c, instr_id, valid_id, m_instr, m_valid);
      end
      tests_run++;
      if ({fault, halted} !== {m_fault, m_halted}) begin
        tests_failed++;
        $display("FAIL rnd_flags cyc=%0d got f/h=%b%b exp %b%b", c, fault, halted, m_fault, m_halted);
      end
      if (m_valid) begin
        tests_run++;
        if ({pc_id, pc4_id} !== {m_pcid, m_pc4}) begin
          tests_failed++;
          $display("FAIL rnd_pc cyc=%0d got pc=%h pc4=%h exp %h/%h", c, pc_id, pc4_id, m_pcid, m_pc4);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; target = 32'h0; halt = 1'b0; resume = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom | 32'h1;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    model_reset();
    test_reset();
    test_boot_run();
    test_stall();
    test_redirect_over_stall();
    test_out_of_range();
    test_misaligned();
    test_halt();
    test_halt_redirect();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
